multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM; drives the ALU op select (aluc) and datapath muxes/write enables.
//  Sits between instruction register (op/func) and the ALU/regfile/memory datapath.
//  Consumes the ALU zero flag for beq.
//  Handshakes with a memory that may insert wait states (mem_rdy).
// PARAMETERS
//  MEM_WAIT_MAX     15  max cycles a memory access may wait for mem_rdy before TRAP (1..255)
//  TRAP_ON_ILLEGAL  1   1: undecodable instruction -> TRAP; 0: treated as NOP (DECODE -> FETCH)
// PORTS
//  clk        in   1  clock, all state updates on rising edge
//  rst        in   1  synchronous reset, active high
//  op         in   6  instr[31:26] from IR (stable from DECODE until next FETCH)
//  func       in   6  instr[5:0] from IR
//  z          in   1  ALU zero flag (R == 0)
//  mem_rdy    in   1  memory completes current access this cycle
//  aluc       out  2  ALU op: 00 add, 01 sub, 10 and, 11 or
//  alu_src_a  out  1  0: PC, 1: reg A
//  alu_src_b  out  2  00: reg B, 01: const 4, 10: ext imm, 11: sext imm<<2
//  zext       out  1  1: imm zero-extended (andi/ori), 0: sign-extended
//  pc_src     out  2  00: ALU result, 01: ALUOut (branch target), 10: jump target
//  pc_wr      out  1  PC write enable
//  ir_wr      out  1  IR write enable
//  iord       out  1  memory address: 0 PC, 1 ALUOut
//  mem_rd     out  1  memory read request
//  mem_wr     out  1  memory write request
//  reg_wr     out  1  register file write enable
//  reg_dst    out  1  1: rd, 0: rt
//  mem_to_reg out  1  1: MDR, 0: ALUOut
//  trap       out  1  sticky fault indicator (illegal op or memory timeout)
// BEHAVIOUR
//  - rst=1: next state FETCH, wait counter 0; outputs are a pure function of state (+mem_rdy/z
//    where noted), so after reset every enable is 0 except mem_rd=1 (FETCH); aluc=00, trap=0.
//  - Reset mid-operation aborts the instruction; no partial write enable is asserted after the rst edge.
//  - Decoded set: R-type (op 000000) func 100000 add, 100010 sub, 100100 and, 100101 or;
//    lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101.
//  - Unlisted outputs are 0 in each state.
//  - FETCH: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, aluc=00, pc_src=00.
//      ir_wr=pc_wr=mem_rdy; mem_rdy -> DECODE, else stay.
//  - DECODE: alu_src_a=0, alu_src_b=11, aluc=00 (branch target into ALUOut). Next state:
//      R -> EXEC_R; lw/sw -> ADDR; beq -> BRANCH; j -> JUMP; addi/andi/ori -> EXEC_I; else illegal.
//  - EXEC_R: alu_src_a=1, alu_src_b=00, aluc from func (add 00, sub 01, and 10, or 11) -> WB_ALU.
//  - EXEC_I: alu_src_a=1, alu_src_b=10; addi: aluc=00, zext=0; andi: 10, zext=1; ori: 11, zext=1.
//      Next state WB_ALU.
//  - ADDR: alu_src_a=1, alu_src_b=10, aluc=00; lw -> MEM_RD, sw -> MEM_WR.
//  - MEM_RD: iord=1, mem_rd=1; mem_rdy -> WB_MEM else stay.
//  - MEM_WR: iord=1, mem_wr=1; mem_rdy -> FETCH else stay.
//  - WB_MEM: reg_wr=1, reg_dst=0, mem_to_reg=1 -> FETCH.
//  - WB_ALU: reg_wr=1, reg_dst=(op==000000), mem_to_reg=0 -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, aluc=01, pc_src=01, pc_wr=z -> FETCH.
//  - JUMP: pc_src=10, pc_wr=1 -> FETCH.
//  - TRAP: all enables 0, trap=1; held until rst.
//  - Illegal op: TRAP_ON_ILLEGAL=1 -> TRAP; =0 -> FETCH (NOP).
//  - Wait counter (8-bit):
//      cleared on entry to FETCH/MEM_RD/MEM_WR; +1 per cycle in those states with mem_rdy=0.
//      If counter==MEM_WAIT_MAX and mem_rdy=0 -> TRAP.
//      mem_rdy=1 in that same cycle wins (access completes normally).
//  - CPI without waits: R/I 4, lw 5, sw 4, beq 3, j 3; each wait cycle adds 1.
// TESTING
//  - rst high 2 cycles mid-MEM_WR -> cycle after release: FETCH, mem_wr=0, reg_wr=0, trap=0.
//  - add (op 0, func 100000), mem_rdy=1 -> 4 cycles; EXEC_R aluc=00; WB_ALU reg_wr=1, reg_dst=1.
//  - lw, mem_rdy low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_MEM mem_to_reg=1; CPI 8.
//  - beq with z=1 -> BRANCH pc_wr=1, pc_src=01, aluc=01; repeat with z=0 -> pc_wr=0.
//  - ori -> EXEC_I aluc=11, zext=1; op 111111 -> trap=1 after DECODE, held until rst.
//  - MEM_WAIT_MAX=15, mem_rdy stuck 0 in FETCH -> TRAP entered on cycle 16; mem_rdy=1 on cycle 16 -> DECODE.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM for a multi-cycle MIPS-style datapath. The instruction
//   register fields (op/func) and the ALU zero flag are decoded into ALU op
//   select, datapath mux selects and write enables. The memory may stretch
//   any access with wait states (mem_rdy low). A bounded wait counter turns
//   a stuck access into a sticky trap.
//
// Parameters
//   MEM_WAIT_MAX    : wait cycles tolerated before a memory access traps (1..255)
//   TRAP_ON_ILLEGAL : 1 = undecodable instruction traps, 0 = executes as NOP
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   op, func        : instruction fields from the IR
//   z               : ALU zero flag (beq)
//   mem_rdy         : memory completes the current access this cycle
//   aluc            : ALU op (00 add, 01 sub, 10 and, 11 or)
//   alu_src_a/_b    : ALU operand selects
//   zext            : immediate zero-extend (andi/ori)
//   pc_src, pc_wr   : PC source select and write enable
//   ir_wr           : IR write enable
//   iord            : memory address select (0 PC, 1 ALUOut)
//   mem_rd, mem_wr  : memory requests
//   reg_wr, reg_dst : register file write enable and destination select
//   mem_to_reg      : register write data select (1 MDR, 0 ALUOut)
//   trap            : sticky fault (illegal instruction or memory timeout)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX    = 15,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_rdy,
  output logic [1:0] aluc,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zext,
  output logic [1:0] pc_src,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       trap
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_MEM = 4'd7,
    S_WB_ALU = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       wait_state;

  // Successor of DECODE for the current instruction; illegal encodings
  // either trap or fall back to FETCH as a NOP.
  function automatic state_t decode_next(input logic [5:0] op_i, input logic [5:0] func_i);
    state_t illegal_nxt;
    illegal_nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
    case (op_i)
      OP_R: begin
        case (func_i)
          FN_ADD, FN_SUB, FN_AND, FN_OR: decode_next = S_EXEC_R;
          default:                       decode_next = illegal_nxt;
        endcase
      end
      OP_LW, OP_SW:              decode_next = S_ADDR;
      OP_BEQ:                    decode_next = S_BRANCH;
      OP_J:                      decode_next = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI:  decode_next = S_EXEC_I;
      default:                   decode_next = illegal_nxt;
    endcase
  endfunction

  // ---- state register and wait counter ----
  // The counter runs while a memory-facing state waits and is zeroed in
  // every other cycle, so each entry into FETCH/MEM_RD/MEM_WR starts at 0.
  assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (wait_state && !mem_rdy) ? wait_cnt + 8'd1 : 8'd0;
    end
  end

  // ---- next-state logic ----
  // In a memory state, mem_rdy takes priority over the timeout so an access
  // that completes on the last permitted cycle is not trapped.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (mem_rdy)                    state_nxt = S_DECODE;
        else if (wait_cnt == WAIT_MAX)  state_nxt = S_TRAP;
      end
      S_DECODE: state_nxt = decode_next(op, func);
      S_EXEC_R: state_nxt = S_WB_ALU;
      S_EXEC_I: state_nxt = S_WB_ALU;
      S_ADDR:   state_nxt = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_rdy)                    state_nxt = S_WB_MEM;
        else if (wait_cnt == WAIT_MAX)  state_nxt = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_rdy)                    state_nxt = S_FETCH;
        else if (wait_cnt == WAIT_MAX)  state_nxt = S_TRAP;
      end
      S_WB_MEM: state_nxt = S_FETCH;
      S_WB_ALU: state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    aluc       = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    zext       = 1'b0;
    pc_src     = 2'b00;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        ir_wr     = mem_rdy;
        pc_wr     = mem_rdy;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        case (func)
          FN_SUB:  aluc = 2'b01;
          FN_AND:  aluc = 2'b10;
          FN_OR:   aluc = 2'b11;
          default: aluc = 2'b00;
        endcase
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op)
          OP_ANDI: begin aluc = 2'b10; zext = 1'b1; end
          OP_ORI:  begin aluc = 2'b11; zext = 1'b1; end
          default: begin aluc = 2'b00; zext = 1'b0; end
        endcase
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
      end
      S_MEM_WR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
      end
      S_WB_MEM: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_WB_ALU: begin
        reg_wr  = 1'b1;
        reg_dst = (op == OP_R);
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluc      = 2'b01;
        pc_src    = 2'b01;
        pc_wr     = z;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_wr  = 1'b1;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. One instance traps on illegal
//   instructions (default), a second runs them as NOPs. Outputs are packed
//   into a 17-bit word {aluc, alu_src_a, alu_src_b, zext, pc_src, pc_wr,
//   ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, trap} and
//   compared per cycle against hand-written expected words.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, func;
  logic       z, mem_rdy;

  logic [1:0] aluc1, src_b1, pc_src1;
  logic       src_a1, zext1, pc_wr1, ir_wr1, iord1, mem_rd1, mem_wr1, reg_wr1, reg_dst1, m2r1, trap1;
  logic [1:0] aluc2, src_b2, pc_src2;
  logic       src_a2, zext2, pc_wr2, ir_wr2, iord2, mem_rd2, mem_wr2, reg_wr2, reg_dst2, m2r2, trap2;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(15), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
    .aluc(aluc1), .alu_src_a(src_a1), .alu_src_b(src_b1), .zext(zext1),
    .pc_src(pc_src1), .pc_wr(pc_wr1), .ir_wr(ir_wr1), .iord(iord1),
    .mem_rd(mem_rd1), .mem_wr(mem_wr1), .reg_wr(reg_wr1), .reg_dst(reg_dst1),
    .mem_to_reg(m2r1), .trap(trap1)
  );

  multicycle_ctrl #(.MEM_WAIT_MAX(15), .TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst(rst), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
    .aluc(aluc2), .alu_src_a(src_a2), .alu_src_b(src_b2), .zext(zext2),
    .pc_src(pc_src2), .pc_wr(pc_wr2), .ir_wr(ir_wr2), .iord(iord2),
    .mem_rd(mem_rd2), .mem_wr(mem_wr2), .reg_wr(reg_wr2), .reg_dst(reg_dst2),
    .mem_to_reg(m2r2), .trap(trap2)
  );

  logic [16:0] out1, out2;
  assign out1 = {aluc1, src_a1, src_b1, zext1, pc_src1, pc_wr1, ir_wr1, iord1,
                 mem_rd1, mem_wr1, reg_wr1, reg_dst1, m2r1, trap1};
  assign out2 = {aluc2, src_a2, src_b2, zext2, pc_src2, pc_wr2, ir_wr2, iord2,
                 mem_rd2, mem_wr2, reg_wr2, reg_dst2, m2r2, trap2};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        z;
    logic        rdy;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t tv[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [16:0] o(
    input logic [1:0] al, input logic a, input logic [1:0] b, input logic zx,
    input logic [1:0] pcs, input logic pcw, input logic irw, input logic io,
    input logic mrd, input logic mwr, input logic rw, input logic rd,
    input logic m2r, input logic tr);
    return {al, a, b, zx, pcs, pcw, irw, io, mrd, mwr, rw, rd, m2r, tr};
  endfunction

  // Expected output words per state
  logic [16:0] F_W, F_R, DEC, ADR, MRD, MWR, WBM, WBA_R, WBA_I, JMP, TRP;
  logic [16:0] EXR_ADD, EXR_SUB, EXR_OR, EXI_ADDI, EXI_ANDI, EXI_ORI, BR_T, BR_N;

  task automatic chk(input string nm, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", nm, got, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the
  // combinational outputs of the current state, then take the rising edge.
  task automatic cyc(input logic r, input logic [5:0] o_i, input logic [5:0] f_i,
                     input logic zz, input logic rdy, input logic [16:0] e1,
                     input logic c2, input logic [16:0] e2, input string nm);
    @(negedge clk);
    rst = r; op = o_i; func = f_i; z = zz; mem_rdy = rdy;
    #1;
    chk(nm, out1, e1);
    if (c2) chk({nm, "_nop"}, out2, e2);
    @(posedge clk);
  endtask

  task automatic add(input logic r, input logic [5:0] o_i, input logic [5:0] f_i,
                     input logic zz, input logic rdy, input logic [16:0] e, input string nm);
    vec_t v;
    v.rst = r; v.op = o_i; v.func = f_i; v.z = zz; v.rdy = rdy; v.exp = e; v.name = nm;
    tv.push_back(v);
  endtask

  initial begin
    //            aluc  a  b     zx pcs   pcw irw io mrd mwr rw rd m2r tr
    F_W      = o(2'b00,0,2'b01,0,2'b00,0, 0,  0, 1,  0,  0, 0, 0,  0);
    F_R      = o(2'b00,0,2'b01,0,2'b00,1, 1,  0, 1,  0,  0, 0, 0,  0);
    DEC      = o(2'b00,0,2'b11,0,2'b00,0, 0,  0, 0,  0,  0, 0, 0,  0);
    EXR_ADD  = o(2'b00,1,2'b00,0,2'b00,0, 0,  0, 0,  0,  0, 0, 0,  0);
    EXR_SUB  = o(2'b01,1,2'b00,0,2'b00,0, 0,  0, 0,  0,  0, 0, 0,  0);
    EXR_OR   = o(2'b11,1,2'b00,0,2'b00,0, 0,  0, 0,  0,  0, 0, 0,  0);
    EXI_ADDI = o(2'b00,1,2'b10,0,2'b00,0, 0,  0, 0,  0,  0, 0, 0,  0);
    EXI_ANDI = o(2'b10,1,2'b10,1,2'b00,0, 0,  0, 0,  0,  0, 0, 0,  0);
    EXI_ORI  = o(2'b11,1,2'b10,1,2'b00,0, 0,  0, 0,  0,  0, 0, 0,  0);
    ADR      = o(2'b00,1,2'b10,0,2'b00,0, 0,  0, 0,  0,  0, 0, 0,  0);
    MRD      = o(2'b00,0,2'b00,0,2'b00,0, 0,  1, 1,  0,  0, 0, 0,  0);
    MWR      = o(2'b00,0,2'b00,0,2'b00,0, 0,  1, 0,  1,  0, 0, 0,  0);
    WBM      = o(2'b00,0,2'b00,0,2'b00,0, 0,  0, 0,  0,  1, 0, 1,  0);
    WBA_R    = o(2'b00,0,2'b00,0,2'b00,0, 0,  0, 0,  0,  1, 1, 0,  0);
    WBA_I    = o(2'b00,0,2'b00,0,2'b00,0, 0,  0, 0,  0,  1, 0, 0,  0);
    BR_T     = o(2'b01,1,2'b00,0,2'b01,1, 0,  0, 0,  0,  0, 0, 0,  0);
    BR_N     = o(2'b01,1,2'b00,0,2'b01,0, 0,  0, 0,  0,  0, 0, 0,  0);
    JMP      = o(2'b00,0,2'b00,0,2'b10,1, 0,  0, 0,  0,  0, 0, 0,  0);
    TRP      = o(2'b00,0,2'b00,0,2'b00,0, 0,  0, 0,  0,  0, 0, 0,  1);

    // Instruction table: one row per cycle, starting in FETCH after reset
    add(0, 6'h00, 6'h00,     0, 0, F_W,      "reset_fetch");
    add(0, 6'h00, 6'b100000, 0, 1, F_R,      "add_fetch");
    add(0, 6'h00, 6'b100000, 0, 1, DEC,      "add_decode");
    add(0, 6'h00, 6'b100000, 0, 1, EXR_ADD,  "add_exec");
    add(0, 6'h00, 6'b100000, 0, 1, WBA_R,    "add_wb");
    add(0, 6'h00, 6'b100010, 0, 1, F_R,      "sub_fetch");
    add(0, 6'h00, 6'b100010, 0, 1, DEC,      "sub_decode");
    add(0, 6'h00, 6'b100010, 0, 1, EXR_SUB,  "sub_exec");
    add(0, 6'h00, 6'b100010, 0, 1, WBA_R,    "sub_wb");
    add(0, 6'h00, 6'b100101, 0, 1, F_R,      "or_fetch");
    add(0, 6'h00, 6'b100101, 0, 1, DEC,      "or_decode");
    add(0, 6'h00, 6'b100101, 0, 1, EXR_OR,   "or_exec");
    add(0, 6'h00, 6'b100101, 0, 1, WBA_R,    "or_wb");
    add(0, 6'b100011, 6'h00, 0, 1, F_R,      "lw_fetch");
    add(0, 6'b100011, 6'h00, 0, 1, DEC,      "lw_decode");
    add(0, 6'b100011, 6'h00, 0, 1, ADR,      "lw_addr");
    add(0, 6'b100011, 6'h00, 0, 0, MRD,      "lw_memrd_w1");
    add(0, 6'b100011, 6'h00, 0, 0, MRD,      "lw_memrd_w2");
    add(0, 6'b100011, 6'h00, 0, 0, MRD,      "lw_memrd_w3");
    add(0, 6'b100011, 6'h00, 0, 1, MRD,      "lw_memrd_done");
    add(0, 6'b100011, 6'h00, 0, 1, WBM,      "lw_wb");
    add(0, 6'b101011, 6'h00, 0, 1, F_R,      "sw_fetch");
    add(0, 6'b101011, 6'h00, 0, 1, DEC,      "sw_decode");
    add(0, 6'b101011, 6'h00, 0, 1, ADR,      "sw_addr");
    add(0, 6'b101011, 6'h00, 0, 1, MWR,      "sw_memwr");
    add(0, 6'b000100, 6'h00, 1, 1, F_R,      "beq_t_fetch");
    add(0, 6'b000100, 6'h00, 1, 1, DEC,      "beq_t_decode");
    add(0, 6'b000100, 6'h00, 1, 1, BR_T,     "beq_taken");
    add(0, 6'b000100, 6'h00, 0, 1, F_R,      "beq_n_fetch");
    add(0, 6'b000100, 6'h00, 0, 1, DEC,      "beq_n_decode");
    add(0, 6'b000100, 6'h00, 0, 1, BR_N,     "beq_not_taken");
    add(0, 6'b000010, 6'h00, 0, 1, F_R,      "j_fetch");
    add(0, 6'b000010, 6'h00, 0, 1, DEC,      "j_decode");
    add(0, 6'b000010, 6'h00, 0, 1, JMP,      "j_jump");
    add(0, 6'b001000, 6'h00, 0, 1, F_R,      "addi_fetch");
    add(0, 6'b001000, 6'h00, 0, 1, DEC,      "addi_decode");
    add(0, 6'b001000, 6'h00, 0, 1, EXI_ADDI, "addi_exec");
    add(0, 6'b001000, 6'h00, 0, 1, WBA_I,    "addi_wb");
    add(0, 6'b001100, 6'h00, 0, 1, F_R,      "andi_fetch");
    add(0, 6'b001100, 6'h00, 0, 1, DEC,      "andi_decode");
    add(0, 6'b001100, 6'h00, 0, 1, EXI_ANDI, "andi_exec");
    add(0, 6'b001100, 6'h00, 0, 1, WBA_I,    "andi_wb");
    add(0, 6'b001101, 6'h00, 0, 1, F_R,      "ori_fetch");
    add(0, 6'b001101, 6'h00, 0, 1, DEC,      "ori_decode");
    add(0, 6'b001101, 6'h00, 0, 1, EXI_ORI,  "ori_exec");
    add(0, 6'b001101, 6'h00, 0, 1, WBA_I,    "ori_wb");

    rst = 1'b1; op = '0; func = '0; z = 1'b0; mem_rdy = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tv[i])
      cyc(tv[i].rst, tv[i].op, tv[i].func, tv[i].z, tv[i].rdy, tv[i].exp, 1'b1, tv[i].exp, tv[i].name);

    // Reset during a stalled sw: writes drop at the reset edge
    cyc(0, 6'b101011, 6'h00, 0, 1, F_R, 1'b1, F_R, "rsw_fetch");
    cyc(0, 6'b101011, 6'h00, 0, 1, DEC, 1'b1, DEC, "rsw_decode");
    cyc(0, 6'b101011, 6'h00, 0, 1, ADR, 1'b1, ADR, "rsw_addr");
    cyc(0, 6'b101011, 6'h00, 0, 0, MWR, 1'b1, MWR, "rsw_memwr_wait");
    cyc(1, 6'b101011, 6'h00, 0, 0, MWR, 1'b1, MWR, "rsw_rst_cycle1");
    cyc(1, 6'b101011, 6'h00, 0, 0, F_W, 1'b1, F_W, "rsw_rst_cycle2");
    cyc(0, 6'b101011, 6'h00, 0, 0, F_W, 1'b1, F_W, "rsw_release");

    // FETCH timeout: 16 waiting cycles, then TRAP (counter 0..15)
    cyc(1, 6'h00, 6'h00, 0, 0, F_W, 1'b1, F_W, "to_reset");
    for (int k = 1; k <= 16; k++)
      cyc(0, 6'h00, 6'h00, 0, 0, F_W, 1'b1, F_W, $sformatf("to_wait_%0d", k));
    cyc(0, 6'h00, 6'h00, 0, 1, TRP, 1'b1, TRP, "to_trap");
    cyc(0, 6'h00, 6'h00, 0, 1, TRP, 1'b1, TRP, "to_trap_held");
    cyc(1, 6'h00, 6'h00, 0, 0, TRP, 1'b1, TRP, "to_trap_rst");

    // mem_rdy on the 16th FETCH cycle still completes the fetch
    for (int k = 1; k <= 15; k++)
      cyc(0, 6'h00, 6'b100000, 0, 0, F_W, 1'b1, F_W, $sformatf("ok_wait_%0d", k));
    cyc(0, 6'h00, 6'b100000, 0, 1, F_R, 1'b1, F_R, "ok_fetch_c16");
    cyc(0, 6'h00, 6'b100000, 0, 1, DEC, 1'b1, DEC, "ok_decode");
    cyc(0, 6'h00, 6'b100000, 0, 1, EXR_ADD, 1'b1, EXR_ADD, "ok_exec");
    cyc(0, 6'h00, 6'b100000, 0, 1, WBA_R, 1'b1, WBA_R, "ok_wb");

    // Illegal opcode: trap in one instance, NOP in the other
    cyc(0, 6'b111111, 6'h00, 0, 1, F_R, 1'b1, F_R, "ill_fetch");
    cyc(0, 6'b111111, 6'h00, 0, 0, DEC, 1'b1, DEC, "ill_decode");
    cyc(0, 6'b111111, 6'h00, 0, 0, TRP, 1'b1, F_W, "ill_after_decode");
    for (int k = 1; k <= 3; k++)
      cyc(0, 6'b111111, 6'h00, 0, 1, TRP, 1'b0, TRP, $sformatf("ill_held_%0d", k));
    cyc(1, 6'h00, 6'h00, 0, 0, TRP, 1'b0, TRP, "ill_rst");
    cyc(0, 6'h00, 6'h00, 0, 0, F_W, 1'b1, F_W, "ill_cleared");

    // Illegal R-type func
    cyc(0, 6'h00, 6'b111111, 0, 1, F_R, 1'b1, F_R, "illf_fetch");
    cyc(0, 6'h00, 6'b111111, 0, 0, DEC, 1'b1, DEC, "illf_decode");
    cyc(0, 6'h00, 6'b111111, 0, 0, TRP, 1'b1, F_W, "illf_after_decode");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
